// File: rtl/priority_pkg.sv
// Shared definitions for the request arbiter: FSM encoding and the
// highest-index-wins selection helpers used for widths other than 4.
package priority_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OFFER = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_t;

  // Helpers operate on a fixed 32-bit vector; callers zero-extend.
  localparam int PRIO_MAXN = 32;
  localparam int PRIO_IDXW = 5;

  // One-hot of the highest set bit, zero when nothing is set.
  function automatic logic [PRIO_MAXN-1:0] prio_onehot(input logic [PRIO_MAXN-1:0] vec);
    logic [PRIO_MAXN-1:0] oh;
    oh = '0;
    for (int i = 0; i < PRIO_MAXN; i++) begin
      if (vec[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  // Binary index of a one-hot vector, zero for an all-zero input.
  function automatic logic [PRIO_IDXW-1:0] onehot_to_idx(input logic [PRIO_MAXN-1:0] oh);
    logic [PRIO_IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < PRIO_MAXN; i++) begin
      if (oh[i]) idx = idx | PRIO_IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_scheme.sv
// Four-way highest-index-wins selector: 1111 -> 1000, 0011 -> 0010.
module priority_scheme (
  input  logic [3:0] req_vec_i,
  output logic [3:0] gnt_onehot_o,
  output logic [1:0] gnt_idx_o
);

  // Pure combinational priority pick; all-zero input yields all-zero grant.
  always_comb begin
    gnt_onehot_o = 4'b0000;
    gnt_idx_o    = 2'd0;
    casez (req_vec_i)
      4'b1???: begin gnt_onehot_o = 4'b1000; gnt_idx_o = 2'd3; end
      4'b01??: begin gnt_onehot_o = 4'b0100; gnt_idx_o = 2'd2; end
      4'b001?: begin gnt_onehot_o = 4'b0010; gnt_idx_o = 2'd1; end
      4'b0001: begin gnt_onehot_o = 4'b0001; gnt_idx_o = 2'd0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/request_arbiter.sv
// Sticky-request arbiter: latches requests into pending bits, offers the
// highest-index pending requester over valid/ready, then holds the grant
// until done or a BUSY timeout.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ARB_IDLE  | no grant outstanding; select from pending when non-zero
//   ARB_OFFER | grant presented with gnt_valid, frozen until gnt_ready
//   ARB_BUSY  | grant accepted; wait for done or timeout abort
module request_arbiter
  import priority_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 8,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  output logic          gnt_valid,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  input  logic          gnt_ready,
  input  logic          done,
  output logic          busy,
  output logic          timeout,
  output logic [N-1:0]  pending
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int             CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0]  CNT_TC  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0]  CNT_MAX = '1;

  arb_state_t    state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  sel_onehot;
  logic [IW-1:0] sel_idx;
  logic [N-1:0]  clr;

  // The 4-wide case uses the dedicated selector; other widths use the
  // package helpers, which produce the same highest-bit-wins result.
  if (N == 4) begin : g_sel4
    priority_scheme u_prio (
      .req_vec_i    (pending_q),
      .gnt_onehot_o (sel_onehot),
      .gnt_idx_o    (sel_idx)
    );
  end else begin : g_selgen
    logic [PRIO_MAXN-1:0] oh_w;
    logic [PRIO_IDXW-1:0] ix_w;
    assign oh_w       = prio_onehot(PRIO_MAXN'(pending_q));
    assign ix_w       = onehot_to_idx(oh_w);
    assign sel_onehot = oh_w[N-1:0];
    assign sel_idx    = ix_w[IW-1:0];
  end

  // Accepted grant clears its pending bit; a same-cycle request re-arms it.
  assign clr       = (valid_q && gnt_ready) ? onehot_q : '0;
  assign pending_d = (pending_q & ~clr) | req;

  // Next-state and registered-output logic for the grant FSM.
  always_comb begin
    state_d   = state_q;
    onehot_d  = onehot_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (|pending_q) begin
          state_d  = ARB_OFFER;
          onehot_d = sel_onehot;
          idx_d    = sel_idx;
          valid_d  = 1'b1;
        end
      end
      ARB_OFFER: begin
        if (gnt_ready) begin
          state_d = ARB_BUSY;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ARB_BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (done) begin
          state_d = ARB_IDLE;
          busy_d  = 1'b0;
        end else if (TO_EN && (cnt_q == CNT_TC)) begin
          state_d   = ARB_IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops everything including pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      pending_q <= '0;
      onehot_q  <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt_valid  = valid_q;
  assign gnt_onehot = onehot_q;
  assign gnt_idx    = idx_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_request_arbiter.sv
// Bench for request_arbiter: cycle model checked every negedge, directed
// scenarios with literal expectations, then randomized traffic.
module tb_request_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 8;

  logic         clk       = 1'b0;
  logic         reset_n   = 1'b1;
  logic [N-1:0] req       = '0;
  logic         gnt_ready = 1'b0;
  logic         done      = 1'b0;
  logic         gnt_valid;
  logic [N-1:0] gnt_onehot;
  logic [1:0]   gnt_idx;
  logic         busy;
  logic         timeout;
  logic [N-1:0] pending;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  request_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_ready  (gnt_ready),
    .done       (done),
    .busy       (busy),
    .timeout    (timeout),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing offered, 1 = offering, 2 = owner working
  int m_pend    = 0;
  int m_phase   = 0;
  int m_owner   = 0;
  int m_oh      = 0;
  int m_worked  = 0;
  int m_to      = 0;

  function automatic int highest(input int v);
    for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    int nxt;
    if (!reset_n) begin
      m_pend = 0; m_phase = 0; m_owner = 0; m_oh = 0; m_worked = 0; m_to = 0;
      return;
    end
    nxt = m_pend;
    if (m_phase == 1 && gnt_ready) nxt = nxt & ~m_oh;
    nxt  = nxt | int'(req);
    m_to = 0;
    case (m_phase)
      0: if (m_pend != 0) begin
           m_owner = highest(m_pend);
           m_oh    = 1 << m_owner;
           m_phase = 1;
         end
      1: if (gnt_ready) begin
           m_phase  = 2;
           m_worked = 0;
         end
      default: begin
        m_worked++;
        if (done) m_phase = 0;
        else if (TIMEOUT != 0 && m_worked == TIMEOUT) begin
          m_phase = 0;
          m_to    = 1;
        end
      end
    endcase
    m_pend = nxt;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pending",    int'(pending),    m_pend);
      chk("m_gnt_valid",  int'(gnt_valid),  (m_phase == 1) ? 1 : 0);
      chk("m_gnt_onehot", int'(gnt_onehot), m_oh);
      chk("m_gnt_idx",    int'(gnt_idx),    m_owner);
      chk("m_busy",       int'(busy),       (m_phase == 2) ? 1 : 0);
      chk("m_timeout",    int'(timeout),    m_to);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (gnt_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    req = '0; gnt_ready = 1'b1; done = 1'b1;
    repeat (16) @(negedge clk);
    gnt_ready = 1'b0; done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int nb;

    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid",   int'(gnt_valid),  0);
    chk("rst_onehot",  int'(gnt_onehot), 0);
    chk("rst_pending", int'(pending),    0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Four simultaneous requests drain highest index first.
    @(negedge clk); req = 4'b1111; gnt_ready = 1'b1; done = 1'b1;
    @(negedge clk); req = '0;
    for (int g = 3; g >= 0; g--) begin
      wait_valid(10, ok);
      chk("d2_offer_seen", int'(ok), 1);
      chk("d2_onehot", int'(gnt_onehot), 1 << g);
      chk("d2_idx",    int'(gnt_idx),    g);
    end
    repeat (4) @(negedge clk);
    chk("d2_pending_empty", int'(pending),   0);
    chk("d2_idle_valid",    int'(gnt_valid), 0);
    chk("d2_idle_busy",     int'(busy),      0);
    drain();

    // Grant frozen in OFFER despite a higher request arriving.
    req = 4'b0001; gnt_ready = 1'b0; done = 1'b0;
    @(negedge clk); req = '0;
    wait_valid(10, ok);
    chk("d3_offer_seen", int'(ok), 1);
    chk("d3_onehot_a", int'(gnt_onehot), 4'b0001);
    req = 4'b1000;
    @(negedge clk); req = '0;
    chk("d3_frozen_onehot", int'(gnt_onehot), 4'b0001);
    chk("d3_frozen_idx",    int'(gnt_idx),    0);
    chk("d3_pending",       int'(pending),    4'b1001);
    @(negedge clk); gnt_ready = 1'b1;
    @(negedge clk); gnt_ready = 1'b0; done = 1'b1;
    chk("d3_busy", int'(busy), 1);
    @(negedge clk); done = 1'b0;
    wait_valid(10, ok);
    chk("d3_offer2_seen", int'(ok), 1);
    chk("d3_onehot_b", int'(gnt_onehot), 4'b1000);
    chk("d3_idx_b",    int'(gnt_idx),    3);
    drain();

    // Timeout after eight BUSY cycles without done.
    req = 4'b0010; gnt_ready = 1'b1; done = 1'b0;
    @(negedge clk); req = '0;
    wait_valid(10, ok);
    chk("d4_offer_seen", int'(ok), 1);
    chk("d4_onehot", int'(gnt_onehot), 4'b0010);
    @(negedge clk); gnt_ready = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      nb++;
      @(negedge clk);
    end
    chk("d4_busy_cycles", nb, 8);
    chk("d4_timeout_pulse", int'(timeout), 1);
    chk("d4_pending1", int'(pending[1]), 0);
    @(negedge clk);
    chk("d4_timeout_one_cycle", int'(timeout), 0);
    drain();

    // Re-request in the accept cycle keeps the pending bit.
    req = 4'b0100; gnt_ready = 1'b1; done = 1'b0;
    @(negedge clk); req = '0;
    wait_valid(10, ok);
    chk("d5_offer_seen", int'(ok), 1);
    chk("d5_onehot_a", int'(gnt_onehot), 4'b0100);
    req = 4'b0100;
    @(negedge clk); req = '0; gnt_ready = 1'b0; done = 1'b1;
    chk("d5_pending_kept", int'(pending), 4'b0100);
    chk("d5_busy", int'(busy), 1);
    @(negedge clk); done = 1'b0;
    wait_valid(10, ok);
    chk("d5_offer2_seen", int'(ok), 1);
    chk("d5_onehot_b", int'(gnt_onehot), 4'b0100);
    drain();

    // done on the last counter value beats the timeout.
    req = 4'b0001; gnt_ready = 1'b1; done = 1'b0;
    @(negedge clk); req = '0;
    wait_valid(10, ok);
    chk("d6_offer_seen", int'(ok), 1);
    @(negedge clk); gnt_ready = 1'b0;
    for (int k = 1; k < 8; k++) @(negedge clk);
    chk("d6_busy_at_8", int'(busy), 1);
    done = 1'b1;
    @(negedge clk); done = 1'b0;
    chk("d6_busy_fell", int'(busy), 0);
    chk("d6_no_timeout", int'(timeout), 0);
    @(negedge clk);
    chk("d6_no_timeout_late", int'(timeout), 0);
    drain();

    // Asynchronous reset mid-BUSY clears outputs before any clock edge.
    req = 4'b0001; gnt_ready = 1'b1; done = 1'b0;
    @(negedge clk); req = '0;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin nb = 1; break; end
    end
    chk("d1_reached_busy", nb, 1);
    gnt_ready = 1'b0; req = 4'b1100;
    @(negedge clk); req = '0;
    chk("d1_pending_before", int'(pending), 4'b1100);
    #2 reset_n = 1'b0;
    #1;
    chk("d1_busy",    int'(busy),       0);
    chk("d1_valid",   int'(gnt_valid),  0);
    chk("d1_onehot",  int'(gnt_onehot), 0);
    chk("d1_idx",     int'(gnt_idx),    0);
    chk("d1_pending", int'(pending),    0);
    chk("d1_timeout", int'(timeout),    0);
    @(negedge clk); reset_n = 1'b1;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      gnt_ready = ($urandom_range(0, 2) != 0);
      done      = ($urandom_range(0, 5) == 0);
      if (c == 1200 || c == 2400) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
